// File: rtl/maquina_maluca_param.sv
// Coffee-machine brew sequencer with batch doses, timed stages, reservoir level,
// cancel, and a served-cup counter.
//
// Ports:
//   clk, rst_n   - clock (rising edge); asynchronous active-low reset
//   start        - begin a batch (sampled only in IDLE)
//   cancel       - abort the current batch (level-sensitive, highest priority)
//   doses        - cups requested, sampled with start (0 means 1)
//   state        - current state code (1..9)
//   busy         - high whenever state != IDLE
//   agua_nivel   - current reservoir level in water units
//   cafe_pronto  - one-cycle pulse after each finished cup
//   xicaras      - cups served since reset (wraps)
module maquina_maluca_param #(
    parameter int unsigned STAGE_CYCLES  = 4,
    parameter int unsigned WATER_CAP     = 8,
    parameter int unsigned WATER_PER_CUP = 3,
    parameter int unsigned DOSE_W        = 3,
    parameter int unsigned CUP_W         = 8,
    localparam int unsigned LVL_W        = $clog2(WATER_CAP + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cancel,
    input  logic [DOSE_W-1:0] doses,
    output logic [3:0]        state,
    output logic              busy,
    output logic [LVL_W-1:0]  agua_nivel,
    output logic              cafe_pronto,
    output logic [CUP_W-1:0]  xicaras
);

    localparam int unsigned TMR_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE                = 4'd1,
        LIGAR_MAQUINA       = 4'd2,
        VERIFICAR_AGUA      = 4'd3,
        ENCHER_RESERVATORIO = 4'd4,
        MOER_CAFE           = 4'd5,
        COLOCAR_NO_FILTRO   = 4'd6,
        PASSAR_AGITADOR     = 4'd7,
        TAMPEAR             = 4'd8,
        REALIZAR_EXTRACAO   = 4'd9
    } state_e;

    state_e              state_q,  state_d;
    logic [TMR_W-1:0]    timer_q,  timer_d;
    logic [DOSE_W-1:0]   rem_q,    rem_d;
    logic [LVL_W-1:0]    agua_q,   agua_d;
    logic [CUP_W-1:0]    cups_q,   cups_d;
    logic                pronto_q, pronto_d;
    logic                stage_last;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            rem_q    <= '0;
            agua_q   <= '0;
            cups_q   <= '0;
            pronto_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            rem_q    <= rem_d;
            agua_q   <= agua_d;
            cups_q   <= cups_d;
            pronto_q <= pronto_d;
        end
    end

    // Next-state and datapath update. Timer defaults to 0 so any state change clears it.
    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        rem_d      = rem_q;
        agua_d     = agua_q;
        cups_d     = cups_q;
        pronto_d   = 1'b0;
        stage_last = (timer_q == TMR_W'(STAGE_CYCLES - 1));

        if (state_q != IDLE && cancel) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !cancel) begin
                        rem_d   = (doses == '0) ? DOSE_W'(1) : doses;
                        state_d = LIGAR_MAQUINA;
                    end
                end
                LIGAR_MAQUINA: state_d = VERIFICAR_AGUA;
                VERIFICAR_AGUA: begin
                    if (agua_q >= LVL_W'(WATER_PER_CUP)) state_d = MOER_CAFE;
                    else                                 state_d = ENCHER_RESERVATORIO;
                end
                ENCHER_RESERVATORIO: begin
                    // Leave on the edge where the level reaches (or already is) full.
                    if (agua_q >= LVL_W'(WATER_CAP - 1)) begin
                        agua_d  = LVL_W'(WATER_CAP);
                        state_d = VERIFICAR_AGUA;
                    end else begin
                        agua_d = agua_q + LVL_W'(1);
                    end
                end
                MOER_CAFE, COLOCAR_NO_FILTRO, PASSAR_AGITADOR, TAMPEAR: begin
                    if (stage_last) state_d = state_e'(4'(state_q) + 4'd1);
                    else            timer_d = timer_q + TMR_W'(1);
                end
                REALIZAR_EXTRACAO: begin
                    if (stage_last) begin
                        agua_d   = agua_q - LVL_W'(WATER_PER_CUP);
                        cups_d   = cups_q + CUP_W'(1);
                        rem_d    = rem_q - DOSE_W'(1);
                        pronto_d = 1'b1;
                        state_d  = (rem_d != '0) ? VERIFICAR_AGUA : IDLE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    assign state       = 4'(state_q);
    assign busy        = (state_q != IDLE);
    assign agua_nivel  = agua_q;
    assign cafe_pronto = pronto_q;
    assign xicaras     = cups_q;

endmodule
